// File: rtl/alu.sv
// RV32 execute-stage ALU: combinational result/zero plus a registered copy
// for the pipeline register path.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       alu_op,
    input  logic             en,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] result_q,
    output logic             zero_q
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLT = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    localparam int MSB = WIDTH - 1;

    // One adder serves ADD, SUB and SLT; SLT reads the sign of op1 - op2.
    logic             use_sub;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             slt_lt;

    assign use_sub = (alu_op == OP_SUB) || (alu_op == OP_SLT);
    assign addend  = use_sub ? ~op2 : op2;
    assign sum     = op1 + addend + {{(WIDTH-1){1'b0}}, use_sub};

    // Differing signs decide directly; otherwise the difference cannot overflow.
    assign slt_lt = (op1[MSB] != op2[MSB]) ? op1[MSB] : sum[MSB];

    // Single right barrel shifter; SLL runs it on the bit-reversed operand.
    logic [4:0]       shamt;
    logic             fill;
    logic [WIDTH-1:0] op1_rev;
    logic [WIDTH-1:0] sh_in;
    logic [WIDTH-1:0] sh_s0;
    logic [WIDTH-1:0] sh_s1;
    logic [WIDTH-1:0] sh_s2;
    logic [WIDTH-1:0] sh_s3;
    logic [WIDTH-1:0] sh_out;
    logic [WIDTH-1:0] sh_out_rev;

    assign shamt = op2[4:0];
    assign fill  = (alu_op == OP_SRA) ? op1[MSB] : 1'b0;

    always_comb begin
        op1_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            op1_rev[i] = op1[MSB-i];
        end
    end

    assign sh_in  = (alu_op == OP_SLL) ? op1_rev : op1;
    assign sh_s0  = shamt[0] ? {fill,         sh_in[MSB:1]}  : sh_in;
    assign sh_s1  = shamt[1] ? {{2{fill}},    sh_s0[MSB:2]}  : sh_s0;
    assign sh_s2  = shamt[2] ? {{4{fill}},    sh_s1[MSB:4]}  : sh_s1;
    assign sh_s3  = shamt[3] ? {{8{fill}},    sh_s2[MSB:8]}  : sh_s2;
    assign sh_out = shamt[4] ? {{16{fill}},   sh_s3[MSB:16]} : sh_s3;

    always_comb begin
        sh_out_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sh_out_rev[i] = sh_out[MSB-i];
        end
    end

    always_comb begin
        result = '0;
        unique case (alu_op)
            OP_AND:  result = op1 & op2;
            OP_OR:   result = op1 | op2;
            OP_ADD:  result = sum;
            OP_SUB:  result = sum;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, slt_lt};
            OP_XOR:  result = op1 ^ op2;
            OP_SRL:  result = sh_out;
            OP_SLL:  result = sh_out_rev;
            OP_SRA:  result = sh_out;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else if (en) begin
            result_q <= result;
            zero_q   <= zero;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver queues expected responses from a
// behavioural model, a negedge monitor pops and compares them.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  alu_op;
    logic        en;
    logic [31:0] result;
    logic        zero;
    logic [31:0] result_q;
    logic        zero_q;

    int checks   = 0;
    int failures = 0;

    alu #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .op1      (op1),
        .op2      (op2),
        .alu_op   (alu_op),
        .en       (en),
        .result   (result),
        .zero     (zero),
        .result_q (result_q),
        .zero_q   (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] exp_r;
        logic        exp_z;
        logic        q_valid;
        logic [31:0] exp_rq;
        logic        exp_zq;
    } item_t;

    item_t sb[$];

    logic [31:0] model_rq;
    logic        model_zq;
    logic        model_valid;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0101: return a ^ b;
            4'b1000: return a >> sh;
            4'b1001: return a << sh;
            4'b1010: return 32'($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Drive one cycle of stimulus; inputs change just after the rising edge.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic e, input logic r);
        item_t it;
        op1    = a;
        op2    = b;
        alu_op = op;
        en     = e;
        rst    = r;
        it.a       = a;
        it.b       = b;
        it.op      = op;
        it.exp_r   = ref_alu(a, b, op);
        it.exp_z   = (it.exp_r == 32'd0);
        it.q_valid = model_valid;
        it.exp_rq  = model_rq;
        it.exp_zq  = model_zq;
        sb.push_back(it);
        @(posedge clk);
        if (r) begin
            model_rq    = 32'd0;
            model_zq    = 1'b1;
            model_valid = 1'b1;
        end else if (e && model_valid) begin
            model_rq = it.exp_r;
            model_zq = it.exp_z;
        end
        #1;
    endtask

    initial begin : monitor
        item_t it;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                it = sb.pop_front();
                check32($sformatf("result op=%b a=%h b=%h", it.op, it.a, it.b), result, it.exp_r);
                check1($sformatf("zero op=%b a=%h b=%h", it.op, it.a, it.b), zero, it.exp_z);
                if (it.q_valid) begin
                    check32("result_q", result_q, it.exp_rq);
                    check1("zero_q", zero_q, it.exp_zq);
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [3:0]  undef_ops[7];
        model_rq    = 32'd0;
        model_zq    = 1'b1;
        model_valid = 1'b0;
        op1 = 32'd0; op2 = 32'd0; alu_op = 4'd0; en = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;

        apply(32'h0, 32'h0, 4'b0000, 1'b0, 1'b1);
        apply(32'hA5A5A5A5, 32'h5A5A5A5A, 4'b0000, 1'b0, 1'b0);
        apply(32'hA5A5A5A5, 32'h5A5A5A5A, 4'b0001, 1'b0, 1'b0);
        apply(32'h12345678, 32'h87654321, 4'b0101, 1'b0, 1'b0);
        apply(32'd50, 32'd30, 4'b0110, 1'b0, 1'b0);
        apply(32'd5, 32'd5, 4'b0110, 1'b0, 1'b0);
        apply(32'h7FFFFFFF, 32'd1, 4'b0010, 1'b0, 1'b0);
        apply(32'd0, 32'd1, 4'b0110, 1'b0, 1'b0);
        apply(32'd10, 32'd20, 4'b0100, 1'b0, 1'b0);
        apply(32'd20, 32'd10, 4'b0100, 1'b0, 1'b0);
        apply(32'hFFFFFFFF, 32'd1, 4'b0100, 1'b0, 1'b0);
        apply(32'd77, 32'd77, 4'b0100, 1'b0, 1'b0);
        apply(32'hFFFFFFFF, 32'd4, 4'b1000, 1'b0, 1'b0);
        apply(32'hFFFFFFFF, 32'd4, 4'b1001, 1'b0, 1'b0);
        apply(32'hFFFFFFFF, 32'd4, 4'b1010, 1'b0, 1'b0);
        apply(32'h80000000, 32'h21, 4'b1010, 1'b0, 1'b0);
        apply(32'h80000000, 32'h21, 4'b1000, 1'b0, 1'b0);
        apply(32'h13579BDF, 32'h0, 4'b1001, 1'b0, 1'b0);
        undef_ops = '{4'b0011, 4'b0111, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
        foreach (undef_ops[i]) apply(32'hDEADBEEF, 32'hCAFEF00D, undef_ops[i], 1'b0, 1'b0);

        // Registered path: capture, hold, reset-over-enable.
        apply(32'd20, 32'd22, 4'b0010, 1'b1, 1'b0);
        apply(32'h11111111, 32'h3, 4'b0001, 1'b0, 1'b0);
        apply(32'h11111111, 32'h3, 4'b0001, 1'b0, 1'b0);
        apply(32'd20, 32'd22, 4'b0010, 1'b1, 1'b1);
        apply(32'd1, 32'd1, 4'b0110, 1'b1, 1'b0);
        apply(32'd9, 32'd9, 4'b0000, 1'b0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            a  = $urandom;
            b  = $urandom;
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = {$urandom_range(0, 1) ? 27'h7FFFFFF : 27'h0, 5'($urandom_range(0, 31))};
                2: a = a | 32'h80000000;
                default: ;
            endcase
            apply(a, b, op, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        end

        apply(32'h0, 32'h0, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
32-bit integer ALU for the RISC-V datapath execute stage. Computes AND/OR/XOR, ADD/SUB, signed SLT and SLL/SRL/SRA from a 4-bit operation code, with a zero flag for branch resolution. `result`/`zero` are combinational for same-cycle use. A registered copy (`result_q`/`zero_q`) feeds the pipeline register path.

Parameters:
WIDTH, 32, operand/result width in bits. Shift amount is always op2[4:0]; WIDTH is fixed at 32 for RV32.

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
op1  input  32  first operand (rs1)
op2  input  32  second operand (rs2 or immediate)
alu_op  input  4  operation select
en  input  1  capture enable for registered outputs
result  output  32  combinational result
zero  output  1  combinational, 1 when result == 0
result_q  output  32  registered result
zero_q  output  1  registered zero flag

Behaviour:
- Opcode map (combinational, no latency):
  - 0000 AND: op1 & op2
  - 0001 OR: op1 | op2
  - 0010 ADD: op1 + op2, modulo 2^32, carry discarded
  - 0110 SUB: op1 - op2, modulo 2^32, borrow discarded
  - 0100 SLT: 32'd1 if $signed(op1) < $signed(op2), else 32'd0
  - 0101 XOR: op1 ^ op2
  - 1000 SRL: op1 >> op2[4:0], zero-fill
  - 1001 SLL: op1 << op2[4:0], zero-fill
  - 1010 SRA: op1 >>> op2[4:0], fill with op1[31]
- Any other alu_op: result = 32'h0, so zero = 1.
- op2[31:5] ignored for all shifts. Shift amount 0 returns op1 unchanged.
- zero = (result == 0) for every opcode, including undefined ones.
- result and zero have no dependence on clk or rst and respond to input changes in the same delta.
- Registered path, evaluated on the rising clk edge:
  - rst = 1: result_q <= 0, zero_q <= 1. rst has priority over en.
  - else if en = 1: result_q <= result, zero_q <= zero.
  - else: result_q and zero_q hold.
- Latency: 0 cycles for combinational outputs; 1 cycle for registered outputs after en is sampled high.
- Reset asserted mid-operation clears the registered outputs on that edge only. Combinational outputs are unaffected by reset.
- No overflow or carry flag. ADD/SUB wrap silently: 0x7FFFFFFF + 1 = 0x80000000, 0 - 1 = 0xFFFFFFFF.
- Output must be purely combinational from inputs: no latches. Every case-branch assigns result.

Test Plan:
- Logic ops: op1=A5A5A5A5, op2=5A5A5A5A.
  - AND -> result 00000000, zero 1.
  - OR -> result FFFFFFFF, zero 0.
  - op1=12345678, op2=87654321, XOR -> result 95511559.
- Arithmetic:
  - ADD 20+22 -> 0000002A.
  - SUB 50-30 -> 00000014.
  - SUB 5-5 -> 0, zero 1.
  - ADD 7FFFFFFF+1 -> 80000000.
  - SUB 0-1 -> FFFFFFFF.
- SLT:
  - 10 vs 20 -> 1.
  - 20 vs 10 -> 0.
  - FFFFFFFF (-1) vs 1 -> 1, signed comparison.
  - equal operands -> 0, zero 1.
- Shifts: op1=FFFFFFFF, op2=4.
  - SRL -> 0FFFFFFF.
  - SLL -> FFFFFFF0.
  - SRA -> FFFFFFFF.
  - op1=80000000, op2=0x21 (amount 1): SRA -> C0000000, SRL -> 40000000.
- Undefined opcodes: sweep alu_op 0011, 0111, 1011–1111 with nonzero operands -> result 0, zero 1.
- Registered path:
  - rst high one edge -> result_q 0, zero_q 1.
  - en=1, ADD 20+22 -> after next edge result_q 2A, zero_q 0.
  - en=0 with changed inputs -> result_q holds 2A.
  - rst and en both high -> result_q 0.
